// File: rtl/pcs_link_ctrl_if.sv
// pcs_link_ctrl_if: management, sync-block and PCS control signals of the link controller
interface pcs_link_ctrl_if;
  logic mr_restart;
  logic sync_status;
  logic rx_even;
  logic [9:0] SUDI;
  logic pcs_rst_n;
  logic xmit;
  logic link_up;
  logic [7:0] link_drops;
  modport master(output mr_restart, sync_status, rx_even, SUDI, input pcs_rst_n, xmit, link_up, link_drops);
  modport slave(input mr_restart, sync_status, rx_even, SUDI, output pcs_rst_n, xmit, link_up, link_drops);
endinterface

// File: rtl/pcs_link_ctrl.sv
// pcs_link_ctrl: 1000BASE-X PCS bring-up sequencer from reset hold through /I/ qualification to data mode
module pcs_link_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int IDLE_MATCH = 3
) (
  input logic GTX_CLK,
  input logic mr_main_reset,
  pcs_link_ctrl_if.slave bus
);
  localparam logic [9:0] K28_5_10 = 10'b0011111010;
  localparam logic [9:0] D5_6_10 = 10'b1010010110;
  localparam logic [9:0] D16_2_10 = 10'b1001000101;
  localparam logic [3:0] HOLD_LAST = 4'(RST_CYCLES - 1);
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_MATCH);
  typedef enum logic [4:0] {
    RESET_HOLD = 5'b00001,
    WAIT_SYNC  = 5'b00010,
    IDLE_CHECK = 5'b00100,
    LINK_UP    = 5'b01000,
    LINK_FAIL  = 5'b10000
  } state_t;
  state_t state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d, idle_cnt_q, idle_cnt_d;
  logic k_seen_q, k_seen_d, good_os;
  logic [7:0] link_drops_q, link_drops_d;
  logic pcs_rst_n_q, pcs_rst_n_d, xmit_q, xmit_d;
  always_comb begin
    state_d = state_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;
    k_seen_d = k_seen_q;
    link_drops_d = link_drops_q;
    good_os = k_seen_q && (bus.SUDI == D5_6_10 || bus.SUDI == D16_2_10);
    if (bus.mr_restart) begin
      state_d = RESET_HOLD;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
      k_seen_d = 1'b0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          state_d = hold_cnt_q == HOLD_LAST ? WAIT_SYNC : RESET_HOLD;
          hold_cnt_d = hold_cnt_q == HOLD_LAST ? '0 : hold_cnt_q + 4'd1;
        end
        WAIT_SYNC: begin
          state_d = bus.sync_status ? IDLE_CHECK : WAIT_SYNC;
          idle_cnt_d = '0;
          k_seen_d = 1'b0;
        end
        IDLE_CHECK: begin
          if (!bus.sync_status) begin
            state_d = WAIT_SYNC;
            idle_cnt_d = '0;
            k_seen_d = 1'b0;
          end else if (bus.rx_even) begin
            k_seen_d = bus.SUDI == K28_5_10;
            idle_cnt_d = bus.SUDI == K28_5_10 ? idle_cnt_q : '0;
          end else begin
            k_seen_d = 1'b0;
            idle_cnt_d = good_os ? idle_cnt_q + 4'd1 : '0;
            state_d = good_os && idle_cnt_q + 4'd1 == IDLE_LAST ? LINK_UP : IDLE_CHECK;
          end
        end
        LINK_UP: begin
          state_d = bus.sync_status ? LINK_UP : LINK_FAIL;
          link_drops_d = !bus.sync_status && link_drops_q != 8'hff ? link_drops_q + 8'd1 : link_drops_q;
        end
        LINK_FAIL: begin
          state_d = RESET_HOLD;
          hold_cnt_d = '0;
        end
        default: begin
          state_d = RESET_HOLD;
          hold_cnt_d = '0;
        end
      endcase
    end
    pcs_rst_n_d = state_d != RESET_HOLD;
    xmit_d = state_d == LINK_UP;
  end
  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state_q <= RESET_HOLD;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
      k_seen_q <= 1'b0;
      link_drops_q <= '0;
      pcs_rst_n_q <= 1'b0;
      xmit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      k_seen_q <= k_seen_d;
      link_drops_q <= link_drops_d;
      pcs_rst_n_q <= pcs_rst_n_d;
      xmit_q <= xmit_d;
    end
  end
  assign bus.pcs_rst_n = pcs_rst_n_q;
  assign bus.xmit = xmit_q;
  assign bus.link_up = xmit_q;
  assign bus.link_drops = link_drops_q;
endmodule

// File: tb/tb_pcs_link_ctrl.sv
// tb_pcs_link_ctrl: scoreboard bench comparing the link controller against a phase-level reference model
module tb_pcs_link_ctrl;
  localparam int RC = 4;
  localparam int IM = 3;
  localparam logic [9:0] K = 10'b0011111010;
  localparam logic [9:0] D56 = 10'b1010010110;
  localparam logic [9:0] D162 = 10'b1001000101;
  localparam int P_HOLD = 0, P_WAIT = 1, P_CHECK = 2, P_UP = 3, P_FAIL = 4;
  typedef struct packed {
    logic rn;
    logic xm;
    logic lu;
    logic [7:0] dr;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pcs_link_ctrl_if bus();
  pcs_link_ctrl #(.RST_CYCLES(RC), .IDLE_MATCH(IM)) dut (.GTX_CLK(clk), .mr_main_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int total = 0, bad = 0;
  int ph = P_HOLD, held = 0, sets = 0, drops = 0;
  bit half_k = 0, ev = 0;
  task automatic model(input bit r, rs, sy, e, input logic [9:0] s);
    if (r) begin
      ph = P_HOLD; held = 0; sets = 0; half_k = 0; drops = 0;
    end else if (rs) begin
      ph = P_HOLD; held = 0; sets = 0; half_k = 0;
    end else if (ph == P_HOLD) begin
      held++;
      if (held == RC) begin ph = P_WAIT; held = 0; end
    end else if (ph == P_WAIT) begin
      if (sy) begin ph = P_CHECK; sets = 0; half_k = 0; end
    end else if (ph == P_CHECK) begin
      if (!sy) begin ph = P_WAIT; sets = 0; half_k = 0; end
      else if (e) begin
        half_k = s == K;
        if (s != K) sets = 0;
      end else begin
        if (half_k && (s == D56 || s == D162)) begin
          sets++;
          if (sets == IM) ph = P_UP;
        end else sets = 0;
        half_k = 0;
      end
    end else if (ph == P_UP) begin
      if (!sy) begin ph = P_FAIL; drops = drops < 255 ? drops + 1 : 255; end
    end else begin
      ph = P_HOLD; held = 0;
    end
  endtask
  task automatic cyc(input bit r, rs, sy, e, input logic [9:0] s);
    exp_t x;
    rst = r;
    bus.mr_restart = rs;
    bus.sync_status = sy;
    bus.rx_even = e;
    bus.SUDI = s;
    model(r, rs, sy, e, s);
    x.rn = ph != P_HOLD;
    x.xm = ph == P_UP;
    x.lu = ph == P_UP;
    x.dr = 8'(drops);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_os(input int n);
    for (int i = 0; i < n; i++) begin
      ev = ~ev;
      cyc(0, 0, 1, ev, ev ? K : D162);
    end
  endtask
  task automatic reach_up();
    int n = 0;
    while (ph != P_UP && n < 100) begin idle_os(1); n++; end
    total++;
    if (ph != P_UP) begin bad++; $display("FAIL reach_up: model phase %0d required %0d", ph, P_UP); end
  endtask
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {bus.pcs_rst_n, bus.xmit, bus.link_up, bus.link_drops};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs @%0t: got rn=%b xm=%b lu=%b drops=%0d required rn=%b xm=%b lu=%b drops=%0d",
                 $time, a.rn, a.xm, a.lu, a.dr, e.rn, e.xm, e.lu, e.dr);
      end
    end
  end
  initial begin
    int r;
    bit rr, rs, sy;
    logic [9:0] s;
    bus.mr_restart = 0; bus.sync_status = 0; bus.rx_even = 0; bus.SUDI = '0;
    cyc(1, 0, 1, 0, K);
    cyc(1, 0, 1, 0, K);
    ev = 1;
    idle_os(16);
    cyc(1, 0, 1, 0, K);
    ev = 1;
    idle_os(7);
    idle_os(4);
    cyc(0, 0, 1, 0, D56);
    cyc(0, 0, 1, 1, D56);
    ev = 1;
    idle_os(8);
    reach_up();
    cyc(0, 0, 0, ~ev, K);
    reach_up();
    idle_os(3);
    cyc(0, 1, 0, ev, K);
    idle_os(2);
    reach_up();
    for (int i = 0; i < 257; i++) begin
      reach_up();
      cyc(0, 0, 0, ev, K);
    end
    idle_os(8);
    cyc(1, 0, 1, ev, K);
    reach_up();
    cyc(1, 0, 1, ev, K);
    idle_os(3);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 7));
      rr = $urandom_range(0, 499) == 0;
      rs = $urandom_range(0, 99) == 0;
      sy = $urandom_range(0, 39) != 0;
      if ($urandom_range(0, 19) != 0) ev = ~ev;
      s = ev ? (r < 6 ? K : 10'($urandom)) : (r < 5 ? D162 : r == 5 ? D56 : 10'($urandom));
      cyc(rr, rs, sy, ev, s);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain: %0d left required 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
